instr_fetch_queue: RTL and testbench



---
 rtl/iq_pkg.sv | 17 +
 rtl/iq_storage.sv | 26 ++
 rtl/instr_fetch_queue.sv | 107 ++++++++++
 tb/tb_instr_fetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package iq_pkg;

   localparam int unsigned IQ_WIDTH = 31;
   localparam int unsigned IQ_DEPTH = 8;
   localparam int unsigned IQ_PTR   = 3;

   // addi x0, x0, 0
   localparam logic [IQ_WIDTH:0] IQ_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [IQ_WIDTH:0] instr;
      logic [IQ_WIDTH:0] pc;
      logic              predTaken;
   } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Entry array for the fetch queue: one write port at tail, asynchronous read at head.
module iq_storage
   import iq_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned PTR   = IQ_PTR
) (
   input  logic           clk,
   input  logic           wr_en_i,
   input  logic [PTR-1:0] wr_ptr_i,
   input  iq_entry_t      wr_data_i,
   input  logic [PTR-1:0] rd_ptr_i,
   output iq_entry_t      rd_data_o
);

   iq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular fetch->decode instruction queue with flush; occupancy drives full/empty.
// Optional same-cycle pass-through when empty: define IQ_BYPASS_EN.
module instr_fetch_queue
   import iq_pkg::*;
#(
   parameter int unsigned WIDTH = IQ_WIDTH,
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned PTR   = IQ_PTR
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           flush,
   input  logic           in_valid,
   input  logic [WIDTH:0] in_instr,
   input  logic [WIDTH:0] in_pc,
   input  logic           in_predTaken,
   output logic           in_ready,
   output logic           out_valid,
   output logic [WIDTH:0] out_instr,
   output logic [WIDTH:0] out_pc,
   output logic           out_predTaken,
   input  logic           out_ready,
   output logic [PTR:0]   count
);

   localparam logic [PTR:0] FULL = (PTR+1)'(DEPTH);

   logic [PTR-1:0] head_q, head_d;
   logic [PTR-1:0] tail_q, tail_d;
   logic [PTR:0]   count_q, count_d;

   iq_entry_t in_entry, rd_entry, head_entry;
   logic      bypass, pass_thru, enq, deq, wr_en, rd_adv;

   assign in_entry.instr     = in_instr;
   assign in_entry.pc        = in_pc;
   assign in_entry.predTaken = in_predTaken;

`ifdef IQ_BYPASS_EN
   assign bypass = (count_q == '0) && in_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != '0) || bypass;
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;

   // A bypassed entry consumed in the same cycle never touches storage or pointers.
   assign pass_thru = bypass && out_ready;
   assign wr_en     = enq && !flush && !pass_thru;
   assign rd_adv    = deq && !flush && !pass_thru;

   iq_storage #(
      .DEPTH (DEPTH),
      .PTR   (PTR)
   ) u_storage (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_ptr_i  (tail_q),
      .wr_data_i (in_entry),
      .rd_ptr_i  (head_q),
      .rd_data_o (rd_entry)
   );

   always_comb begin
      head_entry = bypass ? in_entry : rd_entry;
      if (!out_valid) begin
         head_entry = '0;
      end
   end

   assign out_instr     = head_entry.instr;
   assign out_pc        = head_entry.pc;
   assign out_predTaken = head_entry.predTaken;
   assign count         = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (rd_adv) head_d = head_q + PTR'(1);
         if (wr_en)  tail_d = tail_q + PTR'(1);
         if (wr_en && !rd_adv)      count_d = count_q + (PTR+1)'(1);
         else if (rd_adv && !wr_en) count_d = count_q - (PTR+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue (default build, no bypass).
module tb_instr_fetch_queue;
   import iq_pkg::*;

   logic        clk, reset_n, flush, in_valid, in_predTaken, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_predTaken;
   logic [31:0] out_instr, out_pc;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   iq_entry_t sb[$];

   instr_fetch_queue #(.WIDTH(31), .DEPTH(8), .PTR(3)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .in_predTaken  (in_predTaken),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_predTaken (out_predTaken),
      .out_ready     (out_ready),
      .count         (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_predTaken = 1'b0;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic t, input bit expect_acc);
      in_valid = 1'b1; in_instr = i; in_pc = p; in_predTaken = t;
      if (expect_acc) sb.push_back('{instr: i, pc: p, predTaken: t});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      idle();
      out_ready = 1'b1;
      while (count != 0 && n < 40) begin
         step();
         n++;
      end
      out_ready = 1'b0;
      check({name, "_drained"}, 32'(count), 32'd0);
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compare whatever the DUT hands to decode against the scoreboard.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got pc %h expected no output", out_pc);
         end else begin
            iq_entry_t e;
            e = sb.pop_front();
            check("mon_instr", out_instr, e.instr);
            check("mon_pc", out_pc, e.pc);
            check("mon_pred", 32'(out_predTaken), 32'(e.predTaken));
            pops++;
         end
      end
   end

   initial begin
      int i, cyc, p0;
      bit acc;
      reset_n = 1'b0;
      idle();
      #12;
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_pred", 32'(out_predTaken), 32'd0);
      reset_n = 1'b1;
      step();

      // Single entry, one-cycle latency
      drive(32'h0050_0093, 32'h0, 1'b0, 1'b1);
      check("lat_no_bypass", 32'(out_valid), 32'd0);
      step();
      idle();
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_instr", out_instr, 32'h0050_0093);
      check("single_pc", out_pc, 32'h0);
      check("single_count", 32'(count), 32'd1);
      drain("single");

      // Fill to full, 9th ignored
      for (int k = 0; k < 8; k++) begin
         drive(32'h100 + 32'(k), 32'h1000 + 32'(4*k), k[0], 1'b1);
         step();
      end
      idle();
      check("full_count", 32'(count), 32'd8);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(32'hDEAD, 32'hD000, 1'b1, 1'b0);
      step();
      idle();
      check("ninth_count", 32'(count), 32'd8);
      check("ninth_head", out_instr, 32'h100);
      check("ninth_pc", out_pc, 32'h1000);

      // Full with both handshakes: dequeue only
      drive(32'hBEEF, 32'hB000, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      idle();
      check("fulldeq_count", 32'(count), 32'd7);
      check("fulldeq_in_ready", 32'(in_ready), 32'd1);
      check("fulldeq_head", out_instr, 32'h101);
      drain("full");

      // Stream of 20 with out_ready toggling, across wrap-around
      p0 = pops;
      i = 0;
      cyc = 0;
      while (i < 20 && cyc < 200) begin
         in_valid = 1'b1;
         in_instr = IQ_NOP | (32'(i) << 20);
         in_pc = 32'(4*i);
         in_predTaken = i[1];
         out_ready = (cyc % 2 == 0);
         acc = in_ready;
         if (acc) sb.push_back('{instr: in_instr, pc: in_pc, predTaken: in_predTaken});
         step();
         if (acc) i++;
         cyc++;
      end
      check("stream_issued", 32'(i), 32'd20);
      drain("stream");
      check("stream_pops", 32'(pops - p0), 32'd20);

      // Flush at count=5 with enqueue and dequeue pending
      for (int k = 0; k < 5; k++) begin
         drive(32'h200 + 32'(k), 32'h2000 + 32'(4*k), 1'b1, 1'b1);
         step();
      end
      idle();
      check("preflush_count", 32'(count), 32'd5);
      flush = 1'b1;
      out_ready = 1'b1;
      drive(32'h2FF, 32'h2FFC, 1'b1, 1'b0);
      step();
      idle();
      sb.delete();
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_out_instr", out_instr, 32'd0);
      step();
      check("flush_dropped", 32'(count), 32'd0);

      // Asynchronous reset mid-stream at count=3
      for (int k = 0; k < 3; k++) begin
         drive(32'h300 + 32'(k), 32'h3000 + 32'(4*k), 1'b0, 1'b1);
         step();
      end
      idle();
      check("prerst_count", 32'(count), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      sb.delete();
      check("arst_count", 32'(count), 32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_instr", out_instr, 32'd0);
      check("arst_out_pc", out_pc, 32'd0);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      drive(32'h0000_4AB3, 32'h40, 1'b1, 1'b1);
      step();
      idle();
      check("postrst_count", 32'(count), 32'd1);
      check("postrst_instr", out_instr, 32'h0000_4AB3);
      check("postrst_head_idx", 32'(dut.head_q), 32'd0);
      drain("postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
